morse_key_decoder: RTL and testbench
====================================

// Module: morse_key_decoder
// PURPOSE
//  Front end of the Morse path. It times presses of a single key button and classifies each
//  press as dot or dash. It collects up to 4 symbols and closes the letter after a silent gap.
//  It then emits a one-hot A..Z letter vector that drives the display's per-letter inputs.
//  It also exports live symbol progress (sym_len/sym_bits) for on-screen feedback.
// PARAMETERS
//  TICK_DIV    250000  board_clk cycles per timing tick (1 tick = 2.5 ms at 100 MHz)
//  DASH_TICKS  80      press length >= this is a dash, otherwise a dot
//  GAP_TICKS   240     key-up ticks that close the current letter
//  CNT_W       10      press/gap counter width; counters saturate at 2**CNT_W-1
//  DB_TICKS    4       debounce stable ticks (used only with MORSE_DEBOUNCE_EN)
// PORTS
//  board_clk      in   1   system clock
//  reset          in   1   asynchronous, active-high
//  key_in         in   1   raw key button, active-high, asynchronous to board_clk
//  key_level      out  1   conditioned key level (sidetone/LED)
//  sym_len        out  3   symbols captured in the current letter, 0..4
//  sym_bits       out  4   bit i = symbol i (bit0 = first symbol), 1 = dash, 0 = dot
//  letter_onehot  out  26  bit0 = A .. bit25 = Z; held until the next letter closes
//  letter_valid   out  1   one-cycle pulse when letter_onehot is updated with a valid letter
//  decode_err     out  1   sticky; set on a bad letter, cleared by the next valid letter
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, all counters 0, tick prescaler 0.
//  Clock and reset: board_clk is the clock; reset is asynchronous and active-high.
//  Key conditioning: key_in passes through a 2-flop synchronizer; key_level = sync output.
//    Latency is 2 cycles. key_rise/key_fall are 1-cycle edge strobes of key_level.
//  Timebase: the prescaler counts 0..TICK_DIV-1 and asserts tick on wrap.
//    press_cnt and gap_cnt change only on tick or on clear.
//  FSM:
//   IDLE : sym_len = 0. Only key_rise moves to PRESS; press_cnt <= 0.
//          A key already held when reset deasserts is ignored until it is released.
//   PRESS: press_cnt++ per tick, saturating. On key_fall, go to GAP with gap_cnt <= 0:
//          if sym_len < 4: sym_bits[sym_len] <= (press_cnt >= DASH_TICKS); sym_len++.
//          if sym_len == 4: set the internal ovf flag and drop the symbol.
//   GAP  : gap_cnt++ per tick. key_rise -> PRESS (press_cnt <= 0).
//          gap_cnt == GAP_TICKS -> EMIT.
//   EMIT : single cycle. Look up (sym_len, sym_bits).
//          Valid and !ovf: load letter_onehot, letter_valid = 1, decode_err <= 0.
//          Otherwise: letter_onehot <= 0, decode_err <= 1, no pulse.
//          Then clear sym_len, sym_bits and ovf, and go to IDLE.
//  Invalid codes: 4-symbol patterns ..--, .-.-, ---., ----. An overflow (>4 symbols) is also invalid.
//  Simultaneous events: a key_rise in the same cycle that gap_cnt reaches GAP_TICKS -> EMIT wins.
//    That press is lost because IDLE needs a fresh rise.
//  Reset mid-letter: the partial letter is discarded; letter_onehot returns to 0.
// CONFIGURATION
//  MORSE_DEBOUNCE_EN defined: after the synchronizer, key_level changes only after the synced
//    value has differed from key_level on DB_TICKS consecutive ticks. This adds DB_TICKS ticks
//    of latency to both edges. Pulses shorter than that are rejected.
//  MORSE_DEBOUNCE_EN undefined: no filter; key_level is the synchronizer output; DB_TICKS is unused.
// STRUCTURE
//  morse_pkg: FSM state encoding (IDLE/PRESS/GAP/EMIT) and the 26-entry code table as
//    (len, bits) constants. Also a decode function returning {valid, index[4:0]}.
//    The display side reuses this table.
//  Sub-module morse_key_cond: synchronizer, optional debouncer and edge strobes.
//    The FSM, counters and lookup stay in morse_key_decoder.
// TESTING (bench: TICK_DIV=4, DASH_TICKS=3, GAP_TICKS=5, CNT_W=6, DB_TICKS=2)
//  1. Letter A: press 1 tick, release, press 4 ticks, release, idle 6 ticks
//     -> sym_bits=4'b0010, sym_len=2, then a letter_valid pulse with letter_onehot=26'h1.
//  2. Letter Q (--.-): dash, dash, dot, dash, then gap -> letter_onehot[16]=1.
//     letter_valid lasts exactly 1 cycle. sym_len returns to 0 in the cycle after EMIT.
//  3. Five dots then gap -> decode_err=1, letter_onehot=0.
//     A following valid letter E -> decode_err=0, letter_onehot[4]=1.
//  4. Dash/dot boundary: press of 2 ticks -> dot; press of exactly 3 ticks -> dash.
//     Press of 63+ ticks saturates and is still a dash.
//  5. Key held through reset deassert -> no PRESS until released and pressed again.
//     Reset asserted in GAP -> all outputs 0 within the same cycle.
//  6. With MORSE_DEBOUNCE_EN, a 1-tick glitch on key_in -> no symbol.
//     Without MORSE_DEBOUNCE_EN, the same glitch -> a dot.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared Morse definitions: FSM state encoding, the A..Z code table as
// (length, bits) pairs and a table lookup. The display side reuses the table.
// Symbol encoding: bit i = symbol i (bit0 = first), 1 = dash, 0 = dot.
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS,
        ST_GAP,
        ST_EMIT
    } state_t;

    localparam int NUM_LETTERS = 26;

    localparam logic [2:0] CODE_LEN [NUM_LETTERS] = '{
        3'd2, 3'd4, 3'd4, 3'd3, 3'd1, 3'd4, 3'd3, 3'd4, 3'd2, 3'd4, 3'd3, 3'd4, 3'd2,
        3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd3, 3'd1, 3'd3, 3'd4, 3'd3, 3'd4, 3'd4, 3'd4
    };

    localparam logic [3:0] CODE_BITS [NUM_LETTERS] = '{
        4'b0010, 4'b0001, 4'b0101, 4'b0001, 4'b0000, 4'b0100, 4'b0011, 4'b0000, 4'b0000,
        4'b1110, 4'b0101, 4'b0010, 4'b0011, 4'b0001, 4'b0111, 4'b0110, 4'b1011, 4'b0010,
        4'b0000, 4'b0001, 4'b0100, 4'b1000, 4'b0110, 4'b1001, 4'b1101, 4'b0011
    };

    // Returns {valid, index}; bits above len are masked so stale bits never match.
    function automatic logic [5:0] morse_decode(input logic [2:0] len, input logic [3:0] bits);
        logic [5:0] res;
        logic [3:0] mask;
        res  = '0;
        mask = 4'((5'd1 << len) - 5'd1);
        for (int i = 0; i < NUM_LETTERS; i++) begin
            if (!res[5] && CODE_LEN[i] == len && CODE_BITS[i] == (bits & mask))
                res = {1'b1, 5'(i)};
        end
        return res;
    endfunction

endpackage

// File: rtl/morse_key_decoder_if.sv
// Key input and decoded-letter outputs of the Morse front end.
// slave = decoder side, master = the side driving the key and reading letters.
interface morse_key_decoder_if;
    logic        key_in;
    logic        key_level;
    logic [2:0]  sym_len;
    logic [3:0]  sym_bits;
    logic [25:0] letter_onehot;
    logic        letter_valid;
    logic        decode_err;

    modport master (
        output key_in,
        input  key_level, sym_len, sym_bits, letter_onehot, letter_valid, decode_err
    );

    modport slave (
        input  key_in,
        output key_level, sym_len, sym_bits, letter_onehot, letter_valid, decode_err
    );
endinterface

// File: rtl/morse_key_cond.sv
// Key conditioning: 2-flop synchronizer, optional debouncer (MORSE_DEBOUNCE_EN)
// and edge strobes. Rises are suppressed until the key has been seen released
// once after reset, so a key held through reset never starts a press.
module morse_key_cond #(
    parameter int DB_TICKS = 4
) (
    input  logic board_clk,
    input  logic reset,
    input  logic tick,
    input  logic key_in,
    output logic key_level,
    output logic key_rise,
    output logic key_fall
);

    logic [1:0] sync;
    logic [1:0] primed;
    logic       armed;
    logic       key_prev;

    // synchronizer, plus a marker for when its output reflects the real key
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            sync   <= '0;
            primed <= '0;
        end else begin
            sync   <= {sync[0], key_in};
            primed <= {primed[0], 1'b1};
        end
    end

`ifdef MORSE_DEBOUNCE_EN
    localparam int DB_W = $clog2(DB_TICKS + 1);
    logic [DB_W-1:0] db_cnt;
    logic            db_level;

    // level follows the synced key only after DB_TICKS consecutive differing ticks
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            db_cnt   <= '0;
            db_level <= 1'b0;
        end else if (sync[1] == db_level) begin
            db_cnt <= '0;
        end else if (tick) begin
            if (db_cnt == DB_W'(DB_TICKS - 1)) begin
                db_level <= sync[1];
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    assign key_level = db_level;
`else
    logic unused_db;
    assign unused_db = tick ^ (DB_TICKS == 0);
    assign key_level = sync[1];
`endif

    // arm once a released key is seen; keep previous level for edge detection
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            armed    <= 1'b0;
            key_prev <= 1'b0;
        end else begin
            armed    <= armed | (primed[1] & ~sync[1]);
            key_prev <= key_level;
        end
    end

    assign key_rise = key_level & ~key_prev & armed;
    assign key_fall = ~key_level & key_prev;

endmodule

// File: rtl/morse_key_decoder.sv
// Morse key front end: times key presses in ticks, classifies dot/dash,
// collects up to 4 symbols and emits a one-hot A..Z letter after a silent gap.
// Optional key debouncing is enabled with MORSE_DEBOUNCE_EN (in morse_key_cond).
module morse_key_decoder
    import morse_pkg::*;
#(
    parameter int TICK_DIV   = 250000,
    parameter int DASH_TICKS = 80,
    parameter int GAP_TICKS  = 240,
    parameter int CNT_W      = 10,
    parameter int DB_TICKS   = 4
) (
    input logic          board_clk,
    input logic          reset,
    morse_key_decoder_if.slave bus
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PRE_W-1:0] pre;
    logic             tick;
    logic             key_level, key_rise, key_fall;

    state_t           state;
    logic [CNT_W-1:0] press_cnt, gap_cnt;
    logic             ovf;
    logic [2:0]       sym_len;
    logic [3:0]       sym_bits;
    logic [25:0]      letter_onehot;
    logic             letter_valid, decode_err;
    logic [5:0]       dec;

    morse_key_cond #(.DB_TICKS(DB_TICKS)) u_cond (
        .board_clk (board_clk),
        .reset     (reset),
        .tick      (tick),
        .key_in    (bus.key_in),
        .key_level (key_level),
        .key_rise  (key_rise),
        .key_fall  (key_fall)
    );

    // tick prescaler: tick is high for the one cycle the count sits at its top
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset)
            pre <= '0;
        else if (pre == PRE_W'(TICK_DIV - 1))
            pre <= '0;
        else
            pre <= pre + 1'b1;
    end

    assign tick = (pre == PRE_W'(TICK_DIV - 1));
    assign dec  = morse_decode(sym_len, sym_bits);

    // press/gap timing FSM with symbol capture and letter emission
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            press_cnt     <= '0;
            gap_cnt       <= '0;
            ovf           <= 1'b0;
            sym_len       <= '0;
            sym_bits      <= '0;
            letter_onehot <= '0;
            letter_valid  <= 1'b0;
            decode_err    <= 1'b0;
        end else begin
            letter_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (key_rise) begin
                        state     <= ST_PRESS;
                        press_cnt <= '0;
                    end
                end
                ST_PRESS: begin
                    if (key_fall) begin
                        state   <= ST_GAP;
                        gap_cnt <= '0;
                        if (sym_len < 3'd4) begin
                            sym_bits[sym_len[1:0]] <= (press_cnt >= CNT_W'(DASH_TICKS));
                            sym_len                <= sym_len + 3'd1;
                        end else begin
                            ovf <= 1'b1;
                        end
                    end else if (tick && press_cnt != CNT_MAX) begin
                        press_cnt <= press_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    // gap expiry beats a same-cycle rise; that press is dropped
                    if (gap_cnt == CNT_W'(GAP_TICKS)) begin
                        state <= ST_EMIT;
                    end else if (key_rise) begin
                        state     <= ST_PRESS;
                        press_cnt <= '0;
                    end else if (tick && gap_cnt != CNT_MAX) begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (dec[5] && !ovf) begin
                        letter_onehot <= 26'd1 << dec[4:0];
                        letter_valid  <= 1'b1;
                        decode_err    <= 1'b0;
                    end else begin
                        letter_onehot <= '0;
                        decode_err    <= 1'b1;
                    end
                    sym_len  <= '0;
                    sym_bits <= '0;
                    ovf      <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.key_level     = key_level;
    assign bus.sym_len       = sym_len;
    assign bus.sym_bits      = sym_bits;
    assign bus.letter_onehot = letter_onehot;
    assign bus.letter_valid  = letter_valid;
    assign bus.decode_err    = decode_err;

endmodule

// File: tb/tb_morse_key_decoder.sv
// Bench for morse_key_decoder: a per-cycle reference model built from
// symbol queues and a dot/dash string table, plus directed literal checks
// and a randomized key pattern phase.
module tb_morse_key_decoder;

    localparam int TD   = 4;
    localparam int DASH = 3;
    localparam int GAP  = 5;
    localparam int CNTW = 6;
    localparam int DB   = 2;

    logic board_clk = 1'b0;
    logic reset     = 1'b1;

    morse_key_decoder_if bus ();

    morse_key_decoder #(
        .TICK_DIV   (TD),
        .DASH_TICKS (DASH),
        .GAP_TICKS  (GAP),
        .CNT_W      (CNTW),
        .DB_TICKS   (DB)
    ) dut (
        .board_clk (board_clk),
        .reset     (reset),
        .bus       (bus)
    );

    always #5 board_clk = ~board_clk;

    int total = 0;
    int bad   = 0;

    string codes [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                          ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                          "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          n;
    bit          k1, k2, m_prev, m_armed;
    bit          db_lvl;
    int          db_cnt;
    int          ph;        // 0 waiting for press, 1 pressed, 2 in gap, 3 closing letter
    int          pticks, gticks;
    bit          syms[$];
    logic [25:0] m_onehot;
    bit          m_lv, m_err;
    int          pulses, vcyc, pulse_sym_len;
    bit          lv_prev;

    task automatic model_reset();
        n = 0; k1 = 0; k2 = 0; m_prev = 0; m_armed = 0;
        db_lvl = 0; db_cnt = 0;
        ph = 0; pticks = 0; gticks = 0;
        syms.delete();
        m_onehot = '0; m_lv = 0; m_err = 0; lv_prev = 0;
    endtask

    initial model_reset();

    // one compare per cycle, then advance the model to the next cycle
    always @(negedge board_clk) begin
        bit          syncv, lvl, tk, rise, fall, ok;
        int          len, idx;
        logic [3:0]  eb;
        string       s;
        if (reset) begin
            check("reset_onehot", {6'd0, bus.letter_onehot}, 32'd0);
            check("reset_misc", {22'd0, bus.key_level, bus.sym_len, bus.sym_bits,
                                 bus.letter_valid, bus.decode_err}, 32'd0);
            model_reset();
        end else begin
            syncv = k2;
`ifdef MORSE_DEBOUNCE_EN
            lvl = db_lvl;
`else
            lvl = syncv;
`endif
            tk   = (n % TD) == TD - 1;
            rise = lvl && !m_prev && m_armed;
            fall = !lvl && m_prev;

            len = (syms.size() > 4) ? 4 : syms.size();
            eb  = '0;
            for (int i = 0; i < len; i++) eb[i] = syms[i];

            check("key_level", {31'd0, bus.key_level}, {31'd0, lvl});
            check("sym_len", {29'd0, bus.sym_len}, 32'(len));
            check("sym_bits", {28'd0, bus.sym_bits}, {28'd0, eb});
            check("letter_onehot", {6'd0, bus.letter_onehot}, {6'd0, m_onehot});
            check("letter_valid", {31'd0, bus.letter_valid}, {31'd0, m_lv});
            check("decode_err", {31'd0, bus.decode_err}, {31'd0, m_err});

            if (bus.letter_valid) begin
                vcyc++;
                pulse_sym_len = int'(bus.sym_len);
                if (!lv_prev) pulses++;
            end
            lv_prev = bus.letter_valid;

            m_lv = 0;
            case (ph)
                0: if (rise) begin ph = 1; pticks = 0; end
                1: begin
                    if (fall) begin
                        syms.push_back(pticks >= DASH);
                        ph = 2; gticks = 0;
                    end else if (tk) begin
                        pticks = (pticks + 1 > 63) ? 63 : pticks + 1;
                    end
                end
                2: begin
                    if (gticks == GAP) ph = 3;
                    else if (rise) begin ph = 1; pticks = 0; end
                    else if (tk) gticks++;
                end
                default: begin
                    s = "";
                    foreach (syms[i]) s = {s, syms[i] ? "-" : "."};
                    ok = 0; idx = 0;
                    if (syms.size() <= 4)
                        foreach (codes[i]) if (codes[i] == s) begin ok = 1; idx = i; end
                    if (ok) begin
                        m_onehot = 26'd1 << idx; m_lv = 1; m_err = 0;
                    end else begin
                        m_onehot = '0; m_err = 1;
                    end
                    syms.delete();
                    ph = 0;
                end
            endcase

`ifdef MORSE_DEBOUNCE_EN
            if (syncv == db_lvl) db_cnt = 0;
            else if (tk) begin
                if (db_cnt == DB - 1) begin db_lvl = syncv; db_cnt = 0; end
                else db_cnt++;
            end
`endif
            if (n >= 2 && !syncv) m_armed = 1;
            m_prev = lvl;
            k2 = k1;
            k1 = bus.key_in;
            n++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int c);
        repeat (c) @(posedge board_clk);
        #1;
    endtask

    task automatic key(input bit v, input int c);
        bus.key_in = v;
        cycles(c);
    endtask

    task automatic send(input string code);
        for (int i = 0; i < code.len(); i++) begin
            key(1'b1, (code[i] == "-") ? 16 : 8);
            key(1'b0, 8);
        end
        key(1'b0, 48);
    endtask

    initial begin
        int p0, v0;
        bus.key_in = 1'b0;
        pulses = 0; vcyc = 0; pulse_sym_len = -1;
        repeat (3) @(posedge board_clk);
        #1;
        reset = 1'b0;
        cycles(10);

        // letter A with live progress
        p0 = pulses;
        key(1, 8); key(0, 8); key(1, 16); key(0, 14);
        check("A_sym_len", {29'd0, bus.sym_len}, 32'd2);
        check("A_sym_bits", {28'd0, bus.sym_bits}, 32'b0010);
        key(0, 40);
        check("A_pulses", pulses - p0, 1);
        check("A_onehot", {6'd0, bus.letter_onehot}, 32'h1);

        // letter Q, one-cycle pulse, sym_len cleared with the pulse
        p0 = pulses; v0 = vcyc;
        send("--.-");
        check("Q_onehot", {6'd0, bus.letter_onehot}, 32'h10000);
        check("Q_pulses", pulses - p0, 1);
        check("Q_valid_cycles", vcyc - v0, 1);
        check("Q_sym_len_at_pulse", pulse_sym_len, 0);

        // overflow then recovery with E
        p0 = pulses;
        send(".....");
        check("ovf_err", {31'd0, bus.decode_err}, 32'd1);
        check("ovf_onehot", {6'd0, bus.letter_onehot}, 32'd0);
        check("ovf_pulses", pulses - p0, 0);
        send(".");
        check("E_err", {31'd0, bus.decode_err}, 32'd0);
        check("E_onehot", {6'd0, bus.letter_onehot}, 32'h10);

`ifndef MORSE_DEBOUNCE_EN
        // 2-tick press is a dot, exactly 3 ticks is a dash
        key(1, 9); key(0, 14);
        check("b2_sym_len", {29'd0, bus.sym_len}, 32'd1);
        check("b2_dot", {28'd0, bus.sym_bits}, 32'b0000);
        key(1, 13); key(0, 14);
        check("b3_dash", {28'd0, bus.sym_bits}, 32'b0010);
        key(0, 40);
        check("b_onehot", {6'd0, bus.letter_onehot}, 32'h1);
`endif
        // saturated long press is a dash -> T
        key(1, 280); key(0, 48);
        check("sat_onehot", {6'd0, bus.letter_onehot}, 32'h80000);

        // key held through reset release is ignored
        p0 = pulses;
        bus.key_in = 1'b1; reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        cycles(40);
        key(0, 60);
        check("held_pulses", pulses - p0, 0);
        check("held_err", {31'd0, bus.decode_err}, 32'd0);
        check("held_sym_len", {29'd0, bus.sym_len}, 32'd0);
        send(".");
        check("held_then_E", {6'd0, bus.letter_onehot}, 32'h10);

        // reset asserted during the gap clears outputs immediately
        key(1, 8); key(0, 14);
        check("gap_sym_len", {29'd0, bus.sym_len}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_gap_onehot", {6'd0, bus.letter_onehot}, 32'd0);
        check("rst_gap_sym", {25'd0, bus.sym_len, bus.sym_bits}, 32'd0);
        cycles(3);
        reset = 1'b0;
        key(0, 10);

        // 1-tick glitch
        p0 = pulses;
        key(1, 4); key(0, 48);
`ifdef MORSE_DEBOUNCE_EN
        check("glitch_pulses", pulses - p0, 0);
        check("glitch_onehot", {6'd0, bus.letter_onehot}, 32'd0);
`else
        check("glitch_pulses", pulses - p0, 1);
        check("glitch_onehot", {6'd0, bus.letter_onehot}, 32'h10);
`endif

        // randomized key patterns against the model
        for (int it = 0; it < 300; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            key(1, int'($urandom_range(1, 24)));
            if (r < 7) key(0, int'($urandom_range(1, 20)));
            else       key(0, int'($urandom_range(20, 60)));
        end
        key(0, 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
